// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT result-read path.
package fft_pkg;
   localparam int bit_width = 16;
   localparam int N         = 512;
   localparam int M         = $clog2(N);

   typedef struct packed {
      logic signed [bit_width-1:0] re;
      logic signed [bit_width-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, REPORT} peak_state_t;
endpackage

// File: rtl/cplx_mag_sq.sv
// Registered squared magnitude re^2 + im^2 of one complex sample.
module cplx_mag_sq
   import fft_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  cplx_t                din,
   output logic [2*bit_width:0] mag
);
   logic signed [2*bit_width-1:0] re_sq;
   logic signed [2*bit_width-1:0] im_sq;

   assign re_sq = din.re * din.re;
   assign im_sq = din.im * din.im;

   // Squares are never negative, so the sum is formed unsigned with one carry bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) mag <= '0;
      else        mag <= {1'b0, re_sq} + {1'b0, im_sq};
   end
endmodule

// File: rtl/fft_peak_finder.sv
// Scans positive-frequency FFT bins after done rises and reports the largest |X|^2.
//
//  state  | meaning
//  IDLE   | rd_adr parked at 0, waiting for a done rising edge
//  READ   | issuing one read address per cycle, MIN_BIN..N/2-1
//  DRAIN  | no new reads, letting RAM latency and compare pipeline flush
//  REPORT | peak_valid high, peak_bin/peak_mag just loaded
module fft_peak_finder #(
   parameter int N       = fft_pkg::N,
   parameter int M       = fft_pkg::M,
   parameter int RD_LAT  = 1,
   parameter int MIN_BIN = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           done,
   output logic [M-1:0]                   rd_adr,
   input  logic [2*fft_pkg::bit_width-1:0] rd_data,
   output logic                           busy,
   output logic                           peak_valid,
   output logic [M-2:0]                   peak_bin,
   output logic [2*fft_pkg::bit_width:0]  peak_mag
);
   import fft_pkg::*;

   localparam int              MW         = 2*bit_width + 1;
   localparam logic [M-1:0]    FIRST      = M'(MIN_BIN);
   localparam logic [M-1:0]    LAST       = M'(N/2 - 1);
   localparam int              DW         = $clog2(RD_LAT + 2);
   localparam logic [DW-1:0]   DRAIN_LOAD = DW'(RD_LAT + 1);

   peak_state_t     state;
   logic            done_q;
   logic            start;
   logic [DW-1:0]   drain_cnt;

   logic [M-2:0]    tag_d [RD_LAT];
   logic            vld_d [RD_LAT];
   logic [M-2:0]    s1_tag;
   logic            s1_vld;
   logic [MW-1:0]   mag;

   logic [MW-1:0]   best_mag;
   logic [M-2:0]    best_bin;
   logic            best_ok;

   assign start = done & ~done_q;

   cplx_mag_sq u_mag (
      .clk   (clk),
      .reset (reset),
      .din   (rd_data),
      .mag   (mag)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         done_q     <= 1'b0;
         rd_adr     <= '0;
         busy       <= 1'b0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_mag   <= '0;
         drain_cnt  <= '0;
      end else begin
         done_q     <= done;
         peak_valid <= 1'b0;
         case (state)
            IDLE: begin
               rd_adr <= '0;
               if (start) begin
                  rd_adr <= FIRST;
                  busy   <= 1'b1;
                  state  <= READ;
               end
            end
            READ: begin
               if (rd_adr == LAST) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end else begin
                  rd_adr <= rd_adr + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state      <= REPORT;
                  peak_valid <= 1'b1;
                  peak_bin   <= best_bin;
                  peak_mag   <= best_mag;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            REPORT: begin
               busy   <= 1'b0;
               rd_adr <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bin tag rides alongside the RAM read, then one more stage to meet the registered magnitude.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            tag_d[i] <= '0;
            vld_d[i] <= 1'b0;
         end
         s1_tag   <= '0;
         s1_vld   <= 1'b0;
         best_mag <= '0;
         best_bin <= '0;
         best_ok  <= 1'b0;
      end else begin
         tag_d[0] <= rd_adr[M-2:0];
         vld_d[0] <= (state == READ);
         for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] <= tag_d[i-1];
            vld_d[i] <= vld_d[i-1];
         end
         s1_tag <= tag_d[RD_LAT-1];
         s1_vld <= vld_d[RD_LAT-1];
         if (state == IDLE && start) begin
            best_ok <= 1'b0;
         end else if (s1_vld && (!best_ok || mag > best_mag)) begin
            best_ok  <= 1'b1;
            best_mag <= mag;
            best_bin <= s1_tag;
         end
      end
   end
endmodule
